sdram_burst_seq: RTL and testbench
==================================

Name: sdram_burst_seq

Overview:
- Sits directly downstream of the DAQ cache controller. Converts its wr_req/rd_req burst requests into 256-word burst commands for the SDRAM command core.
- Generates the per-word sdram_wr_ack (wFIFO read strobe) and sdram_rd_ack (rFIFO write strobe) consumed by the cache controller.
- Manages SDRAM as a circular buffer of 256-word bursts, with write/read burst pointers and full/empty tracking.

Parameters:
- PTR_W, 12, burst-pointer width; ring capacity = 2^PTR_W bursts of 256 words.
- TMO_CYC, 1024, watchdog limit in clocks without a data beat (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- sdram_init_done  in  1  SDRAM core initialised
- wr_req  in  1  write-burst request from cache controller (held high ~10 clk)
- rd_req  in  1  read-burst request from cache controller (held high ~11 clk)
- sdram_wr_ack  out  1  one pulse per word written; drives wFIFO rdreq
- sdram_rd_ack  out  1  one pulse per word read; drives rFIFO wrreq
- sys_data_in  in  16  wFIFO q (show-ahead)
- sys_data_out  out  16  read data to rFIFO
- core_cmd_valid  out  1  burst command valid
- core_cmd_ready  in  1  core accepts command
- core_cmd_wr  out  1  1 = write burst, 0 = read burst
- core_cmd_addr  out  PTR_W+8  word address = {ptr, 8'h00}
- core_wdata  out  16  write data to core
- core_wbeat  in  1  core consumes one write word this cycle
- core_rdata  in  16  read data from core
- core_rvalid  in  1  read word valid
- core_done  in  1  core burst finished (precharge done)
- bursts_stored  out  PTR_W+1  bursts currently held
- buf_full  out  1  bursts_stored == 2^PTR_W
- buf_empty  out  1  bursts_stored == 0
- err_flags  out  3  sticky: [0] write dropped (full), [1] read dropped (empty), [2] watchdog abort

Behaviour:
- Reset is asynchronous, active-low: one clock `clk`, reset `rst_n`. All registers clear. All outputs are 0 except buf_empty = 1.
- Request capture:
  - A rising edge of wr_req sets pend_wr; a rising edge of rd_req sets pend_rd (edge detect on registered copies).
  - Edges are ignored while sdram_init_done = 0.
  - A pending flag clears when its burst leaves IDLE.
- States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, WAIT_DONE, WR_DRAIN.
- IDLE transitions:
  - If pend_wr: go to WR_CMD when not full; if full, go to WR_DRAIN and set err_flags[0].
  - Else if pend_rd: go to RD_CMD when not empty; if empty, clear pend_rd, set err_flags[1], stay in IDLE.
  - Writes take priority when both are pending, because wFIFO data is already arriving.
- WR_CMD / RD_CMD:
  - core_cmd_valid = 1, with core_cmd_addr = wptr or rptr concatenated with 8'h00.
  - Advance to the DATA state on core_cmd_valid & core_cmd_ready.
- WR_DATA:
  - sdram_wr_ack = core_wbeat (combinational); core_wdata = sys_data_in.
  - 9-bit beat counter increments per beat; at 256 go to WAIT_DONE.
- RD_DATA:
  - sys_data_out <= core_rdata and sdram_rd_ack <= core_rvalid, both registered (1-clk latency).
  - Counter increments per rvalid; at 256 go to WAIT_DONE.
- WAIT_DONE:
  - On core_done: a write does wptr+1 and bursts_stored+1; a read does rptr+1 and bursts_stored-1. Return to IDLE.
  - Pointers wrap modulo 2^PTR_W.
- WR_DRAIN: pulse sdram_wr_ack once per clock for 256 clocks (discarding wFIFO contents), issue no command, then return to IDLE. Pointers are unchanged.
- Beats arriving beyond 256 in a DATA state are ignored.
- A second request edge during a burst is held pending; at most one of each type is pending. Further edges while pending are lost and are not counted as errors.
- Deasserting rst_n mid-burst aborts immediately; the ring is treated as empty.

Optional Feature:
- Macro SDRAM_BURST_SEQ_TMO_EN.
- When defined: in WR_DATA, RD_DATA and WAIT_DONE, an idle counter resets on each beat or core_done.
  - On reaching TMO_CYC, the FSM returns to IDLE, sets err_flags[2], and leaves pointers and counts unchanged (the burst is discarded).
- When undefined: no watchdog; err_flags[2] is tied to 0.

Test Plan:
- Init: sdram_init_done=0 with a wr_req pulse -> no command, pend_wr not set; raise init_done -> buf_empty=1, bursts_stored=0.
- Single write then read: wr_req edge -> cmd_wr=1, addr=0; 256 core_wbeat -> 256 sdram_wr_ack; after core_done bursts_stored=1. rd_req edge -> cmd addr=0 read; 256 rvalid -> 256 sdram_rd_ack one clk late with matching data; bursts_stored=0.
- Simultaneous wr_req and rd_req edges with 1 stored burst -> write burst first, then read of addr 0; final bursts_stored=1.
- Fill with PTR_W=2 (4 bursts): 4 writes -> buf_full=1; 5th wr_req -> WR_DRAIN emits 256 acks, no command, err_flags[0]=1; 4 reads -> addresses 0x000, 0x100, 0x200, 0x300.
- Read with empty ring -> no command, err_flags[1]=1, FSM back in IDLE next clk.
- With SDRAM_BURST_SEQ_TMO_EN and TMO_CYC=16: stall core_wbeat after 10 beats -> abort at 16 idle clks, err_flags[2]=1, bursts_stored unchanged.

Source files
------------

// File: rtl/sdram_burst_seq_if.sv
// Bus between the burst sequencer and the SDRAM command core.
// Carries one burst command handshake plus the per-word write/read data strobes.
// master = sequencer side, slave = SDRAM command core side.
interface sdram_burst_seq_if #(
  parameter int PTR_W = 12
);
  logic               core_cmd_valid;
  logic               core_cmd_ready;
  logic               core_cmd_wr;
  logic [PTR_W+7:0]   core_cmd_addr;
  logic [15:0]        core_wdata;
  logic               core_wbeat;
  logic [15:0]        core_rdata;
  logic               core_rvalid;
  logic               core_done;

  modport master (
    output core_cmd_valid, core_cmd_wr, core_cmd_addr, core_wdata,
    input  core_cmd_ready, core_wbeat, core_rdata, core_rvalid, core_done
  );

  modport slave (
    input  core_cmd_valid, core_cmd_wr, core_cmd_addr, core_wdata,
    output core_cmd_ready, core_wbeat, core_rdata, core_rvalid, core_done
  );
endinterface

// File: rtl/sdram_burst_seq.sv
// Turns cache-controller wr_req/rd_req edges into 256-word SDRAM burst commands over a burst ring.
// Latency: write ack is combinational with core_wbeat; read data/ack are registered (1 clk).
// Backpressure: command held until core_cmd_ready; data paced entirely by core_wbeat/core_rvalid.
// Ports: clk/rst_n; cache side (sdram_init_done, wr_req, rd_req, sdram_wr_ack, sdram_rd_ack,
//   sys_data_in, sys_data_out); core bus via sdram_burst_seq_if.master; status (bursts_stored,
//   buf_full, buf_empty, err_flags). Define SDRAM_BURST_SEQ_TMO_EN to enable the data-beat watchdog.
module sdram_burst_seq #(
  parameter int PTR_W   = 12,
  parameter int TMO_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdram_init_done,
  input  logic                 wr_req,
  input  logic                 rd_req,
  output logic                 sdram_wr_ack,
  output logic                 sdram_rd_ack,
  input  logic [15:0]          sys_data_in,
  output logic [15:0]          sys_data_out,
  sdram_burst_seq_if.master    core,
  output logic [PTR_W:0]       bursts_stored,
  output logic                 buf_full,
  output logic                 buf_empty,
  output logic [2:0]           err_flags
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_CMD    = 3'd1;
  localparam logic [2:0] S_WR_DATA   = 3'd2;
  localparam logic [2:0] S_RD_CMD    = 3'd3;
  localparam logic [2:0] S_RD_DATA   = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_WR_DRAIN  = 3'd6;

  logic [2:0]       state;
  logic [8:0]       beat_cnt;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             burst_wr;
  logic             pend_wr;
  logic             pend_rd;
  logic             wr_q;
  logic             rd_q;
  logic             wr_edge;
  logic             rd_edge;
  logic             leave_wr;
  logic             leave_rd;
  logic             last_beat;
  logic             tmo_hit;

  // Requests before the SDRAM core is initialised are simply not seen.
  assign wr_edge   = sdram_init_done & wr_req & ~wr_q;
  assign rd_edge   = sdram_init_done & rd_req & ~rd_q;
  assign leave_wr  = (state == S_IDLE) & pend_wr;
  assign leave_rd  = (state == S_IDLE) & ~pend_wr & pend_rd;
  assign last_beat = (beat_cnt == 9'd255);

  assign buf_full  = (bursts_stored == {1'b1, {PTR_W{1'b0}}});
  assign buf_empty = (bursts_stored == '0);

  // Draining discards one wFIFO word per clock without involving the core.
  assign sdram_wr_ack = ((state == S_WR_DATA) & core.core_wbeat) | (state == S_WR_DRAIN);

  assign core.core_cmd_valid = (state == S_WR_CMD) | (state == S_RD_CMD);
  assign core.core_cmd_wr    = (state == S_WR_CMD);
  assign core.core_cmd_addr  = (state == S_WR_CMD) ? {wptr, 8'h00} :
                               (state == S_RD_CMD) ? {rptr, 8'h00} : '0;
  assign core.core_wdata     = (state == S_WR_DATA) ? sys_data_in : 16'h0000;

`ifdef SDRAM_BURST_SEQ_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] idle_cnt;
  logic             watched;
  logic             activity;

  assign watched  = (state == S_WR_DATA) | (state == S_RD_DATA) | (state == S_WAIT_DONE);
  assign activity = ((state == S_WR_DATA) & core.core_wbeat) |
                    ((state == S_RD_DATA) & core.core_rvalid) |
                    ((state == S_WAIT_DONE) & core.core_done);
  // Fires on the TMO_CYC-th consecutive clock without a beat or done.
  assign tmo_hit  = watched & ~activity & (idle_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!watched || activity || tmo_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      beat_cnt      <= '0;
      wptr          <= '0;
      rptr          <= '0;
      burst_wr      <= 1'b0;
      pend_wr       <= 1'b0;
      pend_rd       <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      bursts_stored <= '0;
      err_flags     <= '0;
      sys_data_out  <= '0;
      sdram_rd_ack  <= 1'b0;
    end else begin
      wr_q         <= wr_req;
      rd_q         <= rd_req;
      sdram_rd_ack <= 1'b0;
      // A new edge in the same clock the old request is taken stays pending.
      pend_wr      <= wr_edge | (pend_wr & ~leave_wr);
      pend_rd      <= rd_edge | (pend_rd & ~leave_rd);

      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (pend_wr) begin
            if (buf_full) begin
              state        <= S_WR_DRAIN;
              err_flags[0] <= 1'b1;
            end else begin
              state    <= S_WR_CMD;
              burst_wr <= 1'b1;
            end
          end else if (pend_rd) begin
            if (buf_empty) begin
              err_flags[1] <= 1'b1;
            end else begin
              state    <= S_RD_CMD;
              burst_wr <= 1'b0;
            end
          end
        end
        S_WR_CMD, S_RD_CMD: begin
          if (core.core_cmd_ready) state <= burst_wr ? S_WR_DATA : S_RD_DATA;
        end
        S_WR_DATA: begin
          if (core.core_wbeat) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) state <= S_WAIT_DONE;
          end
        end
        S_RD_DATA: begin
          if (core.core_rvalid) begin
            sys_data_out <= core.core_rdata;
            sdram_rd_ack <= 1'b1;
            beat_cnt     <= beat_cnt + 9'd1;
            if (last_beat) state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (core.core_done) begin
            state <= S_IDLE;
            if (burst_wr) begin
              wptr          <= wptr + 1'b1;
              bursts_stored <= bursts_stored + 1'b1;
            end else begin
              rptr          <= rptr + 1'b1;
              bursts_stored <= bursts_stored - 1'b1;
            end
          end
        end
        S_WR_DRAIN: begin
          beat_cnt <= beat_cnt + 9'd1;
          if (last_beat) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog abort discards the burst: pointers and count stay as they were.
      if (tmo_hit) begin
        state        <= S_IDLE;
        err_flags[2] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_seq.sv
// Directed bench for sdram_burst_seq with a 4-burst ring (PTR_W=2) and TMO_CYC=16.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that point.
module tb_sdram_burst_seq;
  localparam int PTR_W   = 2;
  localparam int TMO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sdram_init_done = 1'b0;
  logic              wr_req = 1'b0;
  logic              rd_req = 1'b0;
  logic [15:0]       sys_data_in = 16'h0000;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [15:0]       sys_data_out;
  logic [PTR_W:0]    bursts_stored;
  logic              buf_full;
  logic              buf_empty;
  logic [2:0]        err_flags;

  int checks = 0;
  int errors = 0;

  sdram_burst_seq_if #(.PTR_W(PTR_W)) core_if ();

  sdram_burst_seq #(.PTR_W(PTR_W), .TMO_CYC(TMO_CYC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wr_req          (wr_req),
    .rd_req          (rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sys_data_in     (sys_data_in),
    .sys_data_out    (sys_data_out),
    .core            (core_if.master),
    .bursts_stored   (bursts_stored),
    .buf_full        (buf_full),
    .buf_empty       (buf_empty),
    .err_flags       (err_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic init);
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    core_if.core_cmd_ready = 1'b0;
    core_if.core_wbeat = 1'b0;
    core_if.core_rvalid = 1'b0;
    core_if.core_done = 1'b0;
    sdram_init_done = init;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic w, input logic r);
    wr_req = w;
    rd_req = r;
    tick();
    tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Waits (bounded) for a command, accepts it with one ready cycle.
  task automatic get_cmd(output logic got, output logic wr, output logic [PTR_W+7:0] addr);
    got = 1'b0;
    wr = 1'b0;
    addr = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (core_if.core_cmd_valid) begin
        got = 1'b1;
        wr = core_if.core_cmd_wr;
        addr = core_if.core_cmd_addr;
        core_if.core_cmd_ready = 1'b1;
        tick();
        core_if.core_cmd_ready = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic write_beats(input int n, output int acks, output int bad);
    acks = 0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      sys_data_in = 16'h5000 + 16'(i);
      core_if.core_wbeat = 1'b1;
      #1;
      if (sdram_wr_ack) acks++;
      if (core_if.core_wdata !== sys_data_in) bad++;
      tick();
    end
    core_if.core_wbeat = 1'b0;
  endtask

  // Checks the registered one-clock latency of read data and ack.
  task automatic read_beats(output int acks, output int bad);
    acks = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      core_if.core_rvalid = 1'b1;
      core_if.core_rdata = 16'hA000 + 16'(i);
      #1;
      if (i == 0 && sdram_rd_ack) bad++;
      tick();
      if (sdram_rd_ack) acks++;
      if (sys_data_out !== 16'hA000 + 16'(i)) bad++;
    end
    core_if.core_rvalid = 1'b0;
    #1;
    if (!sdram_rd_ack) bad++;
    tick();
    if (sdram_rd_ack) bad++;
  endtask

  task automatic done_pulse();
    core_if.core_done = 1'b1;
    tick();
    core_if.core_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({sdram_wr_ack, sdram_rd_ack, core_if.core_cmd_valid, core_if.core_cmd_wr, buf_full, buf_empty} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000001", {sdram_wr_ack, sdram_rd_ack, core_if.core_cmd_valid, core_if.core_cmd_wr, buf_full, buf_empty});
    end
    checks++;
    if ({bursts_stored, err_flags, sys_data_out, core_if.core_cmd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_vectors: stored=%0d err=%b dout=%h addr=%h expected all 0", bursts_stored, err_flags, sys_data_out, core_if.core_cmd_addr);
    end
  endtask

  task automatic test_init();
    int seen;
    reset_dut(1'b0);
    pulse(1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_cmd_valid) seen++;
      tick();
    end
    sdram_init_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_cmd_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL init_no_cmd: got %0d valid cycles expected 0", seen); end
    checks++;
    if (buf_empty !== 1'b1 || bursts_stored !== '0) begin
      errors++;
      $display("FAIL init_status: empty=%b stored=%0d expected 1/0", buf_empty, bursts_stored);
    end
  endtask

  task automatic test_write_read();
    logic got, wr;
    logic [PTR_W+7:0] addr;
    int acks, bad;
    reset_dut(1'b1);
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 10'h000}) begin
      errors++;
      $display("FAIL wr_cmd: got=%b wr=%b addr=%h expected 1/1/000", got, wr, addr);
    end
    write_beats(256, acks, bad);
    checks++;
    if (acks != 256 || bad != 0) begin errors++; $display("FAIL wr_acks: acks=%0d bad=%0d expected 256/0", acks, bad); end
    done_pulse();
    checks++;
    if (bursts_stored !== 3'd1) begin errors++; $display("FAIL wr_stored: got %0d expected 1", bursts_stored); end
    pulse(1'b0, 1'b1);
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b0, 10'h000}) begin
      errors++;
      $display("FAIL rd_cmd: got=%b wr=%b addr=%h expected 1/0/000", got, wr, addr);
    end
    read_beats(acks, bad);
    checks++;
    if (acks != 256 || bad != 0) begin errors++; $display("FAIL rd_acks: acks=%0d bad=%0d expected 256/0", acks, bad); end
    done_pulse();
    checks++;
    if (bursts_stored !== 3'd0 || buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL rd_stored: got %0d empty=%b expected 0/1", bursts_stored, buf_empty);
    end
  endtask

  task automatic test_simultaneous();
    logic got, wr;
    logic [PTR_W+7:0] addr;
    int acks, bad;
    reset_dut(1'b1);
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    write_beats(256, acks, bad);
    done_pulse();
    pulse(1'b1, 1'b1);
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 10'h100}) begin
      errors++;
      $display("FAIL simul_first: got=%b wr=%b addr=%h expected 1/1/100", got, wr, addr);
    end
    write_beats(256, acks, bad);
    done_pulse();
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b0, 10'h000}) begin
      errors++;
      $display("FAIL simul_second: got=%b wr=%b addr=%h expected 1/0/000", got, wr, addr);
    end
    read_beats(acks, bad);
    done_pulse();
    checks++;
    if (bursts_stored !== 3'd1) begin errors++; $display("FAIL simul_stored: got %0d expected 1", bursts_stored); end
  endtask

  task automatic test_fill_and_empty();
    logic got, wr;
    logic [PTR_W+7:0] addr;
    int acks, bad, seen, drain;
    reset_dut(1'b1);
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b0);
      get_cmd(got, wr, addr);
      checks++;
      if ({got, wr, addr} !== {1'b1, 1'b1, 10'(k * 256)}) begin
        errors++;
        $display("FAIL fill_wr_%0d: got=%b wr=%b addr=%h expected 1/1/%h", k, got, wr, addr, 10'(k * 256));
      end
      write_beats(256, acks, bad);
      done_pulse();
    end
    checks++;
    if (buf_full !== 1'b1 || bursts_stored !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: full=%b stored=%0d expected 1/4", buf_full, bursts_stored);
    end
    pulse(1'b1, 1'b0);
    drain = 0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (sdram_wr_ack) drain++;
      if (core_if.core_cmd_valid) seen++;
      tick();
    end
    checks++;
    if (drain != 256 || seen != 0) begin
      errors++;
      $display("FAIL drain: acks=%0d cmds=%0d expected 256/0", drain, seen);
    end
    checks++;
    if (err_flags !== 3'b001 || bursts_stored !== 3'd4) begin
      errors++;
      $display("FAIL drain_flags: err=%b stored=%0d expected 001/4", err_flags, bursts_stored);
    end
    for (int k = 0; k < 4; k++) begin
      pulse(1'b0, 1'b1);
      get_cmd(got, wr, addr);
      checks++;
      if ({got, wr, addr} !== {1'b1, 1'b0, 10'(k * 256)}) begin
        errors++;
        $display("FAIL fill_rd_%0d: got=%b wr=%b addr=%h expected 1/0/%h", k, got, wr, addr, 10'(k * 256));
      end
      read_beats(acks, bad);
      done_pulse();
    end
    checks++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b expected 1", buf_empty); end
    // Ring is now empty: a read is refused.
    pulse(1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_cmd_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || err_flags !== 3'b011) begin
      errors++;
      $display("FAIL rd_empty: cmds=%0d err=%b expected 0/011", seen, err_flags);
    end
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 10'h000}) begin
      errors++;
      $display("FAIL rd_empty_idle: got=%b wr=%b addr=%h expected 1/1/000", got, wr, addr);
    end
    write_beats(256, acks, bad);
    done_pulse();
  endtask

  task automatic test_abort();
    logic got, wr;
    logic [PTR_W+7:0] addr;
    int acks, bad;
    reset_dut(1'b1);
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    write_beats(256, acks, bad);
    done_pulse();
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    write_beats(10, acks, bad);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sdram_wr_ack, core_if.core_cmd_valid, buf_empty, bursts_stored} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL abort: wr_ack=%b valid=%b empty=%b stored=%0d expected 0/0/1/0", sdram_wr_ack, core_if.core_cmd_valid, buf_empty, bursts_stored);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    logic got, wr;
    logic [PTR_W+7:0] addr;
    int acks, bad;
    reset_dut(1'b1);
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    write_beats(10, acks, bad);
    repeat (15) tick();
    checks++;
    if (err_flags !== 3'b000) begin errors++; $display("FAIL stall_15: err=%b expected 000", err_flags); end
`ifdef SDRAM_BURST_SEQ_TMO_EN
    tick();
    checks++;
    if (err_flags !== 3'b100 || bursts_stored !== 3'd0) begin
      errors++;
      $display("FAIL tmo_abort: err=%b stored=%0d expected 100/0", err_flags, bursts_stored);
    end
    pulse(1'b1, 1'b0);
    get_cmd(got, wr, addr);
    checks++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 10'h000}) begin
      errors++;
      $display("FAIL tmo_retry: got=%b wr=%b addr=%h expected 1/1/000", got, wr, addr);
    end
`else
    repeat (30) tick();
    write_beats(246, acks, bad);
    done_pulse();
    checks++;
    if (err_flags !== 3'b000 || bursts_stored !== 3'd1 || acks != 246) begin
      errors++;
      $display("FAIL stall_resume: err=%b stored=%0d acks=%0d expected 000/1/246", err_flags, bursts_stored, acks);
    end
`endif
  endtask

  initial begin
    core_if.core_cmd_ready = 1'b0;
    core_if.core_wbeat = 1'b0;
    core_if.core_rdata = 16'h0000;
    core_if.core_rvalid = 1'b0;
    core_if.core_done = 1'b0;
    test_reset();
    test_init();
    test_write_read();
    test_simultaneous();
    test_fill_and_empty();
    test_abort();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
